// File: rtl/ec_pkg.sv
// Shared types and modular-arithmetic helpers for the short-Weierstrass point adder.
// Helpers work on an EC_MAXW-bit word; callers cast their WIDTH-bit coordinates in and out.
package ec_pkg;

    localparam int EC_MAXW = 64;

    typedef logic [EC_MAXW-1:0] ec_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_NUM,
        ST_INV,
        ST_LAM,
        ST_X3,
        ST_Y3,
        ST_DONE
    } ec_state_e;

    typedef enum logic {
        MODE_ADD,
        MODE_DBL
    } ec_mode_e;

    // Operands must already be reduced below m.
    function automatic ec_word_t mod_add(input ec_word_t a, input ec_word_t b, input ec_word_t m);
        logic [EC_MAXW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[EC_MAXW-1:0];
    endfunction

    function automatic ec_word_t mod_sub(input ec_word_t a, input ec_word_t b, input ec_word_t m);
        return (a >= b) ? (a - b) : (a - b + m);
    endfunction

    function automatic ec_word_t mod_mul(input ec_word_t a, input ec_word_t b, input ec_word_t m);
        logic [2*EC_MAXW-1:0] prod;
        prod = {{EC_MAXW{1'b0}}, a} * {{EC_MAXW{1'b0}}, b};
        return ec_word_t'(prod % {{EC_MAXW{1'b0}}, m});
    endfunction

endpackage

// File: rtl/mod_inv_seq.sv
// Binary extended-Euclid inverse mod P, one halving step per cycle; inv_done pulses k cycles after inv_start.
// No backpressure: result holds in inv until the next inv_start; den = 0 yields 0.
module mod_inv_seq
    import ec_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] P    = WIDTH'(17)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv_start,
    input  logic [WIDTH-1:0] den,
    output logic             inv_done,
    output logic [WIDTH-1:0] inv
);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
    logic [WIDTH-1:0] inv_q, inv_d;

    // x/2 mod P: odd values borrow a P first so the shift is exact.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return WIDTH'(mod_sub(ec_word_t'(a), ec_word_t'(b), ec_word_t'(P)));
    endfunction

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        u_d    = u_q;
        v_d    = v_q;
        x1_d   = x1_q;
        x2_d   = x2_q;
        inv_d  = inv_q;
        if (inv_start) begin
            busy_d = 1'b1;
            u_d    = den;
            v_d    = P;
            x1_d   = WIDTH'(1);
            x2_d   = '0;
        end else if (busy_q) begin
            // Invariants: x1*den == u and x2*den == v (mod P); each step halves u or v.
            if (u_q == '0) begin
                inv_d  = '0;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else if (u_q == WIDTH'(1)) begin
                inv_d  = x1_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else if (v_q == WIDTH'(1)) begin
                inv_d  = x2_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else if (!u_q[0]) begin
                u_d  = u_q >> 1;
                x1_d = half_mod(x1_q);
            end else if (!v_q[0]) begin
                v_d  = v_q >> 1;
                x2_d = half_mod(x2_q);
            end else if (u_q > v_q) begin
                u_d  = (u_q - v_q) >> 1;
                x1_d = half_mod(f_sub(x1_q, x2_q));
            end else begin
                v_d  = (v_q - u_q) >> 1;
                x2_d = half_mod(f_sub(x2_q, x1_q));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            u_q    <= '0;
            v_q    <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            inv_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            u_q    <= u_d;
            v_q    <= v_d;
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            inv_q  <= inv_d;
        end
    end

    assign inv_done = done_q;
    assign inv      = inv_q;

endmodule

// File: rtl/point_adder_seq.sv
// Sequential EC point adder R = P + Q over GF(P); result after 2 cycles (trivial) or 6+k cycles (add/double).
// One operation at a time: in_ready only in IDLE, result held in DONE until out_ready.
module point_adder_seq
    import ec_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] P     = WIDTH'(17),
    parameter logic [WIDTH-1:0] A     = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] px,
    input  logic [WIDTH-1:0] py,
    input  logic [WIDTH-1:0] qx,
    input  logic [WIDTH-1:0] qy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rx,
    output logic [WIDTH-1:0] ry,
    output logic             busy
);

    ec_state_e        state_q, state_d;
    ec_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
    logic [WIDTH-1:0] num_q, num_d, inv_q, inv_d, lam_q, lam_d;
    logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [WIDTH-1:0] mul_a, mul_b, mul_r;
    logic             inv_start, inv_done;
    logic [WIDTH-1:0] inv_den, inv_res;

    function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return WIDTH'(mod_add(ec_word_t'(a), ec_word_t'(b), ec_word_t'(P)));
    endfunction

    function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return WIDTH'(mod_sub(ec_word_t'(a), ec_word_t'(b), ec_word_t'(P)));
    endfunction

    mod_inv_seq #(.WIDTH(WIDTH), .P(P)) u_inv (
        .clk       (clk),
        .rst       (rst),
        .inv_start (inv_start),
        .den       (inv_den),
        .inv_done  (inv_done),
        .inv       (inv_res)
    );

    // Single multiplier shared by every state that needs a product.
    always_comb begin
        mul_a = lam_q;
        mul_b = lam_q;
        case (state_q)
            ST_NUM: begin
                mul_a = px_q;
                mul_b = px_q;
            end
            ST_LAM: begin
                mul_a = num_q;
                mul_b = inv_q;
            end
            ST_Y3: mul_b = f_sub(px_q, rx_q);
            default: ;
        endcase
        mul_r = WIDTH'(mod_mul(ec_word_t'(mul_a), ec_word_t'(mul_b), ec_word_t'(P)));
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        px_d      = px_q;
        py_d      = py_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        num_d     = num_q;
        inv_d     = inv_q;
        lam_d     = lam_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        inv_start = 1'b0;
        inv_den   = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    px_d    = px;
                    py_d    = py;
                    qx_d    = qx;
                    qy_d    = qy;
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (px_q == '0 && py_q == '0) begin
                    rx_d    = qx_q;
                    ry_d    = qy_q;
                    state_d = ST_DONE;
                end else if (qx_q == '0 && qy_q == '0) begin
                    rx_d    = px_q;
                    ry_d    = py_q;
                    state_d = ST_DONE;
                end else if (px_q == qx_q && py_q != qy_q) begin
                    rx_d    = '0;
                    ry_d    = '0;
                    state_d = ST_DONE;
                end else if (px_q == qx_q && py_q == '0) begin
                    rx_d    = '0;
                    ry_d    = '0;
                    state_d = ST_DONE;
                end else if (px_q == qx_q) begin
                    mode_d  = MODE_DBL;
                    state_d = ST_NUM;
                end else begin
                    mode_d  = MODE_ADD;
                    state_d = ST_NUM;
                end
            end
            ST_NUM: begin
                inv_start = 1'b1;
                if (mode_q == MODE_DBL) begin
                    num_d   = f_add(f_add(f_add(mul_r, mul_r), mul_r), A);
                    inv_den = f_add(py_q, py_q);
                end else begin
                    num_d   = f_sub(qy_q, py_q);
                    inv_den = f_sub(qx_q, px_q);
                end
                state_d = ST_INV;
            end
            ST_INV: begin
                if (inv_done) begin
                    inv_d   = inv_res;
                    state_d = ST_LAM;
                end
            end
            ST_LAM: begin
                lam_d   = mul_r;
                state_d = ST_X3;
            end
            ST_X3: begin
                rx_d    = f_sub(f_sub(mul_r, px_q), qx_q);
                state_d = ST_Y3;
            end
            ST_Y3: begin
                ry_d    = f_sub(mul_r, py_q);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ADD;
            px_q    <= '0;
            py_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            num_q   <= '0;
            inv_q   <= '0;
            lam_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            px_q    <= px_d;
            py_q    <= py_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            num_q   <= num_d;
            inv_q   <= inv_d;
            lam_q   <= lam_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign rx        = rx_q;
    assign ry        = ry_q;

endmodule

// File: doc/point_adder_seq.md
# point_adder_seq

Multi-cycle, parametrised elliptic-curve point adder for short-Weierstrass curves y² = x³ + A·x + b over GF(P). It is the sequential successor to the combinational point adder. One shared arithmetic path is sequenced by an FSM. The modular inverse is computed by an iterative sub-module, so wide curves close timing. Operands arrive and results leave through valid/ready handshakes, so the block sits directly under the scalar-multiplication controller.

## Interface
Parameters:
- WIDTH, 8: coordinate width in bits; P < 2^WIDTH.
- P, 17: field prime, odd, ≥ 3.
- A, 2: curve coefficient a, 0 ≤ A < P.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- px, py, qx, qy  in  WIDTH each  operand points P and Q, fully reduced; (0,0) encodes the point at infinity.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rx, ry  out  WIDTH each  result R = P + Q; (0,0) encodes infinity.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CLASSIFY, NUM, INV, LAM, X3, Y3, DONE.
- IDLE: in_ready=1. When in_valid is high, capture px..qy into internal registers and go to CLASSIFY.
- CLASSIFY: the checks below are evaluated in priority order.
  - P = (0,0) → R = Q, go to DONE.
  - Q = (0,0) → R = P, go to DONE.
  - px = qx and py ≠ qy → R = (0,0), go to DONE. This covers Q = −P.
  - P = Q and py = 0 → R = (0,0), go to DONE.
  - P = Q → doubling mode, go to NUM.
  - Otherwise → addition mode, go to NUM.
- NUM:
  - Addition mode: num = qy − py, den = qx − px.
  - Doubling mode: num = 3·px² + A, den = 2·py.
  - Pulse inv_start with den, then go to INV.
- INV: wait for inv_done, then latch inv = den⁻¹ mod P and go to LAM.
- LAM: lam = num·inv, then go to X3.
- X3: rx = lam² − px − qx, then go to Y3.
- Y3: ry = lam·(px − rx) − py, then go to DONE.
- DONE: out_valid=1 and rx/ry hold stable. When out_ready is high, go to IDLE.
- Arithmetic rules:
  - All results are fully reduced to [0, P).
  - Subtraction adds P on borrow.
  - Multiplication forms a 2·WIDTH product, then reduces it mod P.
  - Intermediate sums are WIDTH+1 bits before reduction.
- Operands ≥ P are outside the contract; results for them are undefined.
- rx/ry are registered and change only in CLASSIFY, X3 and Y3.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, rx=0, ry=0. The inverter also returns to idle.
- Reset mid-operation: the operation is abandoned with no output. in_ready=1 on the first edge after rst deasserts.
- Call the accepting edge t.
  - Trivial cases (infinity or inverse): out_valid is high from cycle t+2.
  - Add/double cases: out_valid is high from cycle t+6+k, where k is the number of inverter cycles.
- Inverter latency k satisfies 1 ≤ k ≤ 2·WIDTH+2.
- A new operand set is accepted no earlier than the edge after the out_valid&&out_ready handshake. There is no overlap between operations.
- out_valid and rx/ry stay stable while out_ready=0, for an unbounded time.
- in_valid arriving while busy is ignored. The source must hold it until it sees in_ready.

## Structure
- Package ec_pkg holds:
  - the FSM state enum;
  - the mode enum (ADD, DBL);
  - parametrised functions mod_add, mod_sub and mod_mul (WIDTH, P as arguments).
- Sub-module mod_inv_seq is a binary extended-Euclid inverter with parameters WIDTH and P.
  - Ports: clk, rst, inv_start, den, inv_done (1-cycle pulse), inv.
  - For den = 0 it returns 0. This is unreachable from the adder FSM.

## Test plan
All scenarios use WIDTH=8, P=17, A=2 (curve y² = x³ + 2x + 2).
- Doubling: (5,1)+(5,1) → (6,3). out_valid stays held 5 cycles with out_ready=0 and rx/ry stay stable throughout.
- Addition: (5,1)+(6,3) → (10,6). Check that total latency is 6+k cycles and that k ≤ 18.
- Inverse: (5,1)+(5,16) → (0,0). out_valid high at t+2.
- Infinity operands: (0,0)+(6,3) → (6,3), and (10,6)+(0,0) → (10,6), both at t+2.
- Back-to-back: drive the scalar chain P, 2P, 3P … 19P = (0,0) with out_ready tied high. Check the results against a software model and check that no input is accepted while busy=1.
- Reset: assert rst during INV of (5,1)+(6,3). Check that outputs return to their reset values immediately and that the next operation (5,1)+(5,1) gives (6,3).
